// File: rtl/fp_clk_div_pkg.sv
// Shared types and constants for the fractional clock-enable divider.
package fp_clk_div_pkg;

  localparam int INT_W_DEF = 24;
  localparam int MIN_INT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [INT_W_DEF-1:0] int_part;
    logic [15:0]          frac_part;
  } div_t;

endpackage

// File: rtl/fp_ce_core.sv
// Period engine: counts m through int-1+carry, steps the 16-bit phase
// accumulator at each period end and decodes registered tick/tick180/clk_out.
module fp_ce_core
  import fp_clk_div_pkg::*;
#(
  parameter int          INT_W    = INT_W_DEF,
  parameter int unsigned DEF_INT  = 27,
  parameter logic [15:0] DEF_FRAC = 16'hEFBF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [INT_W-1:0] div_int_i,
  input  logic [15:0]      div_frac_i,
  output logic             last_o,
  output logic             tick_o,
  output logic             tick180_o,
  output logic             clk_out_o
);

  logic [INT_W-1:0] int_q, int_d;
  logic [15:0]      frac_q, frac_d;
  logic [INT_W-1:0] m_q, m_d;
  logic [15:0]      acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             tick_q, tick_d;
  logic             tick180_q, tick180_d;
  logic             clk_out_q, clk_out_d;

  logic [INT_W:0]   last_cnt;
  logic [INT_W-1:0] half;
  logic [16:0]      acc_sum;

  // Final count is int-1+carry; one extra bit so a wide carry never wraps.
  assign last_cnt = {1'b0, int_q} - (INT_W+1)'(1) + {{INT_W{1'b0}}, carry_q};
  assign last_o   = ({1'b0, m_q} == last_cnt);
  assign half     = int_q >> 1;
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_q};

  // Next-state of counter/accumulator and registered output decode.
  always_comb begin
    int_d     = int_q;
    frac_d    = frac_q;
    m_d       = m_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    tick_d    = run_i & last_o;
    tick180_d = run_i & (m_q == half);
    clk_out_d = run_i & (m_q < half);
    if (load_i) begin
      int_d   = div_int_i;
      frac_d  = div_frac_i;
      m_d     = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (clr_i) begin
      m_d     = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (run_i) begin
      if (last_o) begin
        m_d              = '0;
        {carry_d, acc_d} = acc_sum;
      end else begin
        m_d = m_q + INT_W'(1);
      end
    end
  end

  // Engine state registers; reset restores the default divisor.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      int_q     <= INT_W'(DEF_INT);
      frac_q    <= DEF_FRAC;
      m_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      tick_q    <= 1'b0;
      tick180_q <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      int_q     <= int_d;
      frac_q    <= frac_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      tick_q    <= tick_d;
      tick180_q <= tick180_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign tick_o    = tick_q;
  assign tick180_o = tick180_q;
  assign clk_out_o = clk_out_q;

endmodule

// File: rtl/fp_clk_div_ctrl.sv
// Controller for the fractional clock-enable engine: run/drain FSM, config
// handshake with shadow register, glitch-free divisor swap at period end,
// and the tick counter.
module fp_clk_div_ctrl
  import fp_clk_div_pkg::*;
#(
  parameter int          INT_W    = INT_W_DEF,
  parameter int unsigned DEF_INT  = 27,
  parameter logic [15:0] DEF_FRAC = 16'hEFBF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [INT_W-1:0] cfg_int,
  input  logic [15:0]      cfg_frac,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             tick,
  output logic             tick180,
  output logic             clk_out,
  output logic             running,
  output logic             cfg_pending,
  output logic [15:0]      period_cnt,
  output logic [1:0]       dbg_state_o
);

  // Config handshake: a request transfers on a clock edge where cfg_valid and
  // cfg_ready are both 1. cfg_ready depends only on state, never on cfg_valid.
  // The requester holds cfg_valid/cfg_int/cfg_frac stable until that edge.
  // A transferred request with cfg_int below MIN_INT is consumed and answered
  // with a cfg_err pulse; otherwise it is answered later with cfg_done.

  state_e           state_q, state_d;
  logic [INT_W-1:0] sh_int_q, sh_int_d;
  logic [15:0]      sh_frac_q, sh_frac_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             ready_w, req_w, int_ok_w, accept_w, run_w;
  logic             last_w, load_w, clr_w;
  logic [INT_W-1:0] ld_int_w;
  logic [15:0]      ld_frac_w;

  assign ready_w  = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign req_w    = cfg_valid & ready_w;
  assign int_ok_w = (cfg_int >= INT_W'(MIN_INT));
  assign accept_w = req_w & int_ok_w;
  assign run_w    = (state_q != ST_IDLE);

  fp_ce_core #(
    .INT_W    (INT_W),
    .DEF_INT  (DEF_INT),
    .DEF_FRAC (DEF_FRAC)
  ) u_core (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .run_i      (run_w),
    .clr_i      (clr_w),
    .load_i     (load_w),
    .div_int_i  (ld_int_w),
    .div_frac_i (ld_frac_w),
    .last_o     (last_w),
    .tick_o     (tick),
    .tick180_o  (tick180),
    .clk_out_o  (clk_out)
  );

  // FSM next state, shadow capture, engine load/clear strobes and pulses.
  always_comb begin
    state_d   = state_q;
    sh_int_d  = sh_int_q;
    sh_frac_d = sh_frac_q;
    load_w    = 1'b0;
    clr_w     = 1'b0;
    ld_int_w  = cfg_int;
    ld_frac_w = cfg_frac;
    done_d    = 1'b0;
    err_d     = req_w & ~int_ok_w;
    pcnt_d    = pcnt_q + {15'd0, run_w & last_w};
    case (state_q)
      ST_IDLE: begin
        // Engine is idle, so a new divisor can go straight in.
        if (accept_w) begin
          load_w = 1'b1;
          done_d = 1'b1;
        end
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept_w) begin
          sh_int_d  = cfg_int;
          sh_frac_d = cfg_frac;
          state_d   = ST_PEND;
        end else if (!enable) begin
          if (last_w) begin
            clr_w   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_PEND: begin
        // Swap only on a period end so clk_out never shows a runt phase.
        if (last_w) begin
          load_w    = 1'b1;
          ld_int_w  = sh_int_q;
          ld_frac_w = sh_frac_q;
          done_d    = 1'b1;
          state_d   = enable ? ST_RUN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (last_w) begin
          clr_w   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; reset drops any pending shadow divisor.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      sh_int_q  <= '0;
      sh_frac_q <= '0;
      pcnt_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_int_q  <= sh_int_d;
      sh_frac_q <= sh_frac_d;
      pcnt_q    <= pcnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready   = ready_w;
  assign running     = run_w;
  assign cfg_pending = (state_q == ST_PEND);
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign period_cnt  = pcnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_clk_div_ctrl.sv
// Bench for fp_clk_div_ctrl: closed-form period model plus directed and
// random stimulus.
module tb_fp_clk_div_ctrl;

  localparam int INT_W = 24;
  localparam int M_IDLE = 0, M_RUN = 1, M_PEND = 2, M_DRAIN = 3;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [INT_W-1:0] cfg_int = '0;
  logic [15:0]      cfg_frac = '0;
  logic             cfg_ready, cfg_done, cfg_err, tick, tick180, clk_out;
  logic             running, cfg_pending;
  logic [15:0]      period_cnt;
  logic [1:0]       dbg_state;

  fp_clk_div_ctrl dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_int     (cfg_int),
    .cfg_frac    (cfg_frac),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .tick        (tick),
    .tick180     (tick180),
    .clk_out     (clk_out),
    .running     (running),
    .cfg_pending (cfg_pending),
    .period_cnt  (period_cnt),
    .dbg_state_o (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Within a divisor epoch the k-th period (1-based) ends after
  // k*int + floor((k-1)*frac/65536) advancing cycles.
  int     ms;
  longint ai, af, si, sf, ep, kk;
  int     pcnt;
  bit     ex_tick, ex_t180, ex_clk, ex_done, ex_err;

  function automatic longint period_end(input longint k, input longint iv, input longint fv);
    return k * iv + (((k - 1) * fv) >> 16);
  endfunction

  task automatic model_reset();
    ms = M_IDLE; ai = 27; af = 16'hEFBF; si = 0; sf = 0; ep = 0; kk = 0; pcnt = 0;
    ex_tick = 0; ex_t180 = 0; ex_clk = 0; ex_done = 0; ex_err = 0;
  endtask

  task automatic model_step();
    bit rdy, req, good, adv, last;
    longint pos, half, st;
    rdy  = (ms == M_IDLE) || (ms == M_RUN);
    req  = cfg_valid && rdy;
    good = (cfg_int >= 2);
    adv  = (ms != M_IDLE);
    last = 0; pos = 0; half = ai >> 1;
    if (adv) begin
      st   = (kk == 0) ? 0 : period_end(kk, ai, af);
      last = (ep + 1 == period_end(kk + 1, ai, af));
      pos  = ep - st;
    end
    ex_tick = adv && last;
    ex_t180 = adv && (pos == half);
    ex_clk  = adv && (pos < half);
    ex_err  = req && !good;
    ex_done = 0;
    if (adv) ep++;
    if (adv && last) begin
      kk++;
      pcnt = (pcnt + 1) & 16'hFFFF;
    end
    case (ms)
      M_IDLE: begin
        if (req && good) begin ai = cfg_int; af = cfg_frac; ep = 0; kk = 0; ex_done = 1; end
        if (enable) ms = M_RUN;
      end
      M_RUN: begin
        if (req && good) begin si = cfg_int; sf = cfg_frac; ms = M_PEND; end
        else if (!enable) begin
          if (last) begin ms = M_IDLE; ep = 0; kk = 0; end
          else ms = M_DRAIN;
        end
      end
      M_PEND: begin
        if (last) begin
          ai = si; af = sf; ep = 0; kk = 0; ex_done = 1;
          ms = enable ? M_RUN : M_IDLE;
        end
      end
      default: begin
        if (enable) ms = M_RUN;
        else if (last) begin ms = M_IDLE; ep = 0; kk = 0; end
      end
    endcase
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) model_reset();
    else model_step();
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk_in) begin
    if (chk_on) begin
      chk("tick", tick, ex_tick);
      chk("tick180", tick180, ex_t180);
      chk("clk_out", clk_out, ex_clk);
      chk("cfg_done", cfg_done, ex_done);
      chk("cfg_err", cfg_err, ex_err);
      chk("running", running, ms != M_IDLE);
      chk("cfg_pending", cfg_pending, ms == M_PEND);
      chk("cfg_ready", cfg_ready, (ms == M_IDLE) || (ms == M_RUN));
      chk("period_cnt", period_cnt, pcnt);
    end
  end

  // ---------------- event recorder ----------------
  int cyc = 0;
  int tick_times[$];
  int t180_times[$];
  int done_times[$];
  int rise_at_tick[$];
  int err_cnt = 0;
  int rises = 0;
  logic prev_clk = 1'b0;

  always begin
    @(posedge clk_in);
    cyc++;
    #1;
    if (clk_out === 1'b1 && prev_clk === 1'b0) rises++;
    prev_clk = clk_out;
    if (tick === 1'b1) begin tick_times.push_back(cyc); rise_at_tick.push_back(rises); end
    if (tick180 === 1'b1) t180_times.push_back(cyc);
    if (cfg_done === 1'b1) done_times.push_back(cyc);
    if (cfg_err === 1'b1) err_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick_cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic send_cfg(input logic [INT_W-1:0] iv, input logic [15:0] fv);
    int guard;
    guard = 0;
    @(negedge clk_in);
    cfg_int = iv; cfg_frac = fv; cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk_in);
      guard++;
    end
    chk("cfg_accept_within_budget", cfg_ready, 1'b1);
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int target, input int budget, input string name);
    int guard;
    guard = 0;
    while (tick_times.size() < target && guard < budget) begin
      @(negedge clk_in);
      guard++;
    end
    chk(name, tick_times.size() >= target, 1'b1);
  endtask

  task automatic check_spacings(input int idx, input string name);
    int i;
    logic [31:0] e;
    i = idx;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (i + 1 < tick_times.size()) chk(name, tick_times[i+1] - tick_times[i], e);
      else begin
        n_cmp++; n_bad++;
        $display("FAIL %s: tick %0d missing, expected spacing %0d", name, i + 1, e);
      end
      i++;
    end
  endtask

  // ---------------- stimulus ----------------
  int b, b2, d0, e0, n0, span, r, found;

  initial begin
    #1 rst_in = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("reset_cfg_ready", cfg_ready, 1'b1);
    chk("reset_running", running, 1'b0);
    rst_in = 1'b0;

    // 1: defaults, 1000 periods
    @(negedge clk_in); enable = 1'b1;
    b = tick_times.size();
    wait_ticks(b + 1001, 40000, "t1_ticks");
    if (tick_times.size() >= b + 1001) begin
      span = tick_times[b+1000] - tick_times[b];
      n_cmp++;
      if (span < 27935 || span > 27937) begin
        n_bad++;
        $display("FAIL t1_span1000: got %0d expected 27936+/-1", span);
      end
      chk("t1_clk_rises", rise_at_tick[b+1000] - rise_at_tick[b], 1000);
    end

    // 2: IDLE config int=4 frac=0x8000
    @(negedge clk_in); enable = 1'b0;
    do_reset();
    d0 = done_times.size();
    send_cfg(24'd4, 16'h8000);
    chk("t2_idle_done", done_times.size() - d0, 1);
    @(negedge clk_in); enable = 1'b1;
    b = tick_times.size();
    wait_ticks(b + 6, 2000, "t2_ticks");
    exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(4);
    exp_q.push_back(5); exp_q.push_back(4);
    check_spacings(b, "t2_spacing");
    found = 0;
    foreach (t180_times[i]) if (found == 0 && t180_times[i] > tick_times[b]) found = t180_times[i];
    chk("t2_tick180_offset", found - tick_times[b], 3);

    // 3: retune 10 -> 6 mid-period
    do_reset();
    send_cfg(24'd10, 16'h0);
    @(negedge clk_in); enable = 1'b1;
    b = tick_times.size();
    wait_ticks(b + 2, 2000, "t3_pre_ticks");
    tick_cycles(3);
    send_cfg(24'd6, 16'h0);
    chk("t3_ready_low", cfg_ready, 1'b0);
    chk("t3_pending", cfg_pending, 1'b1);
    wait_ticks(b + 5, 2000, "t3_post_ticks");
    exp_q.push_back(10); exp_q.push_back(6); exp_q.push_back(6);
    check_spacings(b + 1, "t3_spacing");
    if (tick_times.size() > b + 2 && done_times.size() > 0)
      chk("t3_done_with_tick", done_times[done_times.size()-1], tick_times[b+2]);

    // 4: illegal divisor rejected
    b2 = tick_times.size();
    e0 = err_cnt;
    d0 = done_times.size();
    send_cfg(24'd1, 16'h1234);
    chk("t4_err_pulse", err_cnt - e0, 1);
    wait_ticks(b2 + 3, 2000, "t4_ticks");
    chk("t4_no_done", done_times.size() - d0, 0);
    exp_q.push_back(6); exp_q.push_back(6);
    check_spacings(b2, "t4_spacing");

    // 5: drain and re-enable during drain
    @(negedge clk_in); enable = 1'b0;
    do_reset();
    send_cfg(24'd10, 16'h0);
    @(negedge clk_in); enable = 1'b1;
    b = tick_times.size();
    wait_ticks(b + 1, 2000, "t5_first_tick");
    tick_cycles(3);
    enable = 1'b0;
    wait_ticks(b + 2, 2000, "t5_drain_tick");
    exp_q.push_back(10);
    check_spacings(b, "t5_drain_spacing");
    tick_cycles(2);
    chk("t5_idle_running", running, 1'b0);
    chk("t5_idle_clk_out", clk_out, 1'b0);
    n0 = tick_times.size();
    tick_cycles(30);
    chk("t5_no_tick_after_drain", tick_times.size() - n0, 0);
    enable = 1'b1;
    b = tick_times.size();
    wait_ticks(b + 1, 2000, "t5_restart_tick");
    tick_cycles(3);
    enable = 1'b0;
    tick_cycles(2);
    chk("t5_draining_running", running, 1'b1);
    enable = 1'b1;
    wait_ticks(b + 3, 2000, "t5_resume_ticks");
    exp_q.push_back(10); exp_q.push_back(10);
    check_spacings(b, "t5_no_gap_spacing");

    // 6: async reset while a divisor is pending
    do_reset();
    send_cfg(24'd8, 16'h0);
    @(negedge clk_in); enable = 1'b1;
    b = tick_times.size();
    wait_ticks(b + 1, 2000, "t6_first_tick");
    tick_cycles(2);
    send_cfg(24'd5, 16'h0);
    chk("t6_pending_before_reset", cfg_pending, 1'b1);
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk("t6_rst_tick", tick, 1'b0);
    chk("t6_rst_tick180", tick180, 1'b0);
    chk("t6_rst_clk_out", clk_out, 1'b0);
    chk("t6_rst_done", cfg_done, 1'b0);
    chk("t6_rst_err", cfg_err, 1'b0);
    chk("t6_rst_running", running, 1'b0);
    chk("t6_rst_pending", cfg_pending, 1'b0);
    chk("t6_rst_period_cnt", period_cnt, 16'd0);
    chk("t6_rst_ready", cfg_ready, 1'b1);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    b = tick_times.size();
    wait_ticks(b + 3, 2000, "t6_resume_ticks");
    exp_q.push_back(27); exp_q.push_back(28);
    check_spacings(b, "t6_def_spacing");
    chk("t6_period_cnt", period_cnt, 16'd3);

    // random phase
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        @(negedge clk_in);
        enable = ~enable;
      end else if (r <= 5) begin
        send_cfg(INT_W'($urandom_range(0, 14)), 16'($urandom));
      end else if (r == 6 && $urandom_range(0, 7) == 0) begin
        do_reset();
      end else begin
        tick_cycles($urandom_range(1, 25));
      end
    end
    tick_cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
